uart_show_tx: RTL and testbench
===============================

Name: uart_show_tx

Overview:
- Downstream consumer of the top-level debug trace snapshot (tx_show / show_len).
- Captures one snapshot and serialises its valid bytes over an 8N1 UART line, most significant valid byte first.
- Sits between the core-level top and the board TX pin.
- Snapshots presented while a transmission is in progress are dropped and counted, never queued.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- MAX_BYTES, 16, snapshot width in bytes; tx_show is MAX_BYTES*8 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_show  input  128  snapshot; valid bytes are the low show_len bytes
- show_len  input  5  number of bytes to send; legal 1..16
- show_valid  input  1  one-cycle pulse: snapshot present this cycle
- show_ready  output  1  high when IDLE; snapshot accepted on show_valid & show_ready
- tx  output  1  UART serial line, idles high
- busy  output  1  high from the cycle after accept until the last stop bit completes
- drop_cnt  output  8  saturating count of show_valid pulses seen while not ready

Behaviour:
- Reset (synchronous, active-high), values in the cycle after reset is sampled:
  - tx=1, show_ready=1, busy=0, drop_cnt=0, state=IDLE, all counters 0.
  - Reset mid-frame aborts immediately; tx returns to 1 and the partial byte is not completed.
- Accept: in IDLE with show_valid=1, latch tx_show into shreg and latch eff_len.
  - eff_len = min(show_len, 16).
  - show_len=0: accepted, nothing sent, state stays IDLE, busy never rises, drop_cnt unchanged.
- Byte order:
  - Byte k = shreg[8k+7:8k]; send k = eff_len-1 down to 0.
  - Example: len 12 sends bits 95:88 first and 7:0 last.
  - Each byte is sent LSB first.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept with eff_len != 0. tx=0 in the cycle after accept, so latency to start-bit edge is 1 cycle.
  - START: tx=0 for CLK_DIV cycles -> DATA.
  - DATA: tx = current bit, CLK_DIV cycles per bit, bit_idx 0..7. After bit 7 -> STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then, if bytes remain, decrement the byte index -> START with no idle gap. Otherwise -> IDLE.
- Frame time: eff_len*10*CLK_DIV cycles from the first start-bit cycle to the return to IDLE.
- Counters and widths:
  - Baud counter 16 bits; counts 0..CLK_DIV-1 and wraps at CLK_DIV-1, which marks the bit boundary.
  - bit_idx 3 bits. byte_idx 5 bits.
- Handshake and drops:
  - show_ready = (state==IDLE); busy = ~show_ready.
  - show_valid when show_ready=0 increments drop_cnt, saturating at 255; the snapshot is discarded.
  - show_valid on the same cycle the FSM returns to IDLE is still a drop, because ready is registered state.
  - show_valid on the following cycle is accepted.
- Input stability: tx_show and show_len are sampled only on the accept cycle. Later changes have no effect on the frame in flight.

Decomposition:
- Shared package holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP}
  - localparam UART_DATA_BITS=8
  - localparam SHOW_MAX_BYTES=16
- One natural sub-module, uart_bit_timer:
  - Baud counter with enable/clear.
  - Emits a one-cycle bit_tick every CLK_DIV cycles.
- The top FSM consumes bit_tick.

Test Plan (CLK_DIV=4):
1. Reset held 3 cycles, then released -> tx=1, show_ready=1, busy=0, drop_cnt=0; tx stays 1 for 50 idle cycles.
2. show_len=2, tx_show low bytes 16'hA55A, one-cycle show_valid:
   - tx low the next cycle.
   - Line carries 0xA5 then 0x5A, LSB first with start/stop bits, total 80 cycles.
   - Then show_ready=1.
3. show_len=16, tx_show=128'h00112233_44556677_8899AABB_CCDDEEFF -> decoded bytes 00,11,...,FF in that order; busy high exactly 640 cycles.
4. Three show_valid pulses during transfer from scenario 2 -> drop_cnt=3; the in-flight frame is unchanged. 300 pulses during a long frame -> drop_cnt=255.
5. show_len=0 with show_valid -> tx stays 1, busy stays 0, drop_cnt unchanged. show_len=20 -> exactly 16 bytes sent.
6. Reset asserted mid-DATA of byte 1 -> tx=1 and state IDLE the next cycle. A new show_valid after release sends a clean full frame.

Source files
------------

// File: rtl/uart_show_tx_pkg.sv
// Shared types and constants for the debug-snapshot UART transmitter.
package uart_show_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned SHOW_MAX_BYTES = 16;
  localparam int unsigned SHOW_LEN_W     = 5;
  localparam int unsigned BAUD_CNT_W     = 16;
  localparam int unsigned BIT_IDX_W      = 3;
  localparam int unsigned DROP_CNT_W     = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Requested byte count limited to the snapshot width.
  function automatic logic [SHOW_LEN_W-1:0] clamp_len(input logic [SHOW_LEN_W-1:0] len,
                                                      input logic [SHOW_LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/uart_show_tx_if.sv
// Snapshot handshake plus UART line/status bundle.
interface uart_show_tx_if
  import uart_show_tx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = SHOW_MAX_BYTES
) ();

  logic [MAX_BYTES*UART_DATA_BITS-1:0] tx_show;
  logic [SHOW_LEN_W-1:0]               show_len;
  logic                                show_valid;
  logic                                show_ready;
  logic                                tx;
  logic                                busy;
  logic [DROP_CNT_W-1:0]               drop_cnt;

  modport master (
    output tx_show, show_len, show_valid,
    input  show_ready, tx, busy, drop_cnt
  );

  modport slave (
    input  tx_show, show_len, show_valid,
    output show_ready, tx, busy, drop_cnt
  );

endinterface

// File: rtl/uart_show_tx_bit_timer.sv
// Baud counter: one-cycle bit_tick_c at the end of every CLK_DIV-cycle bit period.
module uart_bit_timer
  import uart_show_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic bit_tick_c
);

  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLK_DIV - 1);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    bit_tick_c = en && (cnt_q == LAST_CNT);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_tick_c ? '0 : cnt_q + BAUD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_show_tx.sv
// Captures a trace snapshot and sends its valid bytes, most significant first, as 8N1 UART.
module uart_show_tx
  import uart_show_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned MAX_BYTES = SHOW_MAX_BYTES
) (
  input  logic           clk,
  input  logic           reset,
  uart_show_tx_if.slave  bus
);

  localparam int unsigned SHREG_W   = MAX_BYTES * UART_DATA_BITS;
  localparam int unsigned BIT_SEL_W = $clog2(SHREG_W);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [SHREG_W-1:0]    shreg_q, shreg_d;
  logic [SHOW_LEN_W-1:0] byte_idx_q, byte_idx_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [SHOW_LEN_W-1:0] eff_len_c;
  logic [BIT_SEL_W-1:0]  bit_sel_c;
  logic                  bit_tick_c;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (state_q != IDLE),
    .clr        (state_q == IDLE),
    .bit_tick_c (bit_tick_c)
  );

  assign eff_len_c = clamp_len(bus.show_len, SHOW_LEN_W'(MAX_BYTES));

  // Next state, datapath and registered line/status outputs.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    drop_d     = drop_q;

    unique case (state_q)
      IDLE: begin
        if (bus.show_valid && (eff_len_c != '0)) begin
          shreg_d    = bus.tx_show;
          byte_idx_d = eff_len_c - SHOW_LEN_W'(1);
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_tick_c) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_tick_c) begin
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
        end
      end
      STOP: begin
        if (bit_tick_c) begin
          if (byte_idx_q != '0) begin
            byte_idx_d = byte_idx_q - SHOW_LEN_W'(1);
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered, so a pulse on the return-to-IDLE cycle is still a drop.
    if (bus.show_valid && (state_q != IDLE) && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end

    bit_sel_c = BIT_SEL_W'({byte_idx_d, bit_idx_d});
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_sel_c];
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      drop_q     <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      drop_q     <= drop_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.show_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_show_tx.sv
// Directed + randomized bench for uart_show_tx against a bit-period line model.
module tb_uart_show_tx;
  import uart_show_tx_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_show_tx_if #(.MAX_BYTES(16)) bus ();

  uart_show_tx #(.CLK_DIV(DIV), .MAX_BYTES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int drop_exp  = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},    32'(bus.tx), 32'd1);
    chk({tag, "_ready"}, 32'(bus.show_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_drop"},  32'(bus.drop_cnt), 32'(drop_exp));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends one snapshot and checks the line against the expected 10-bit frames.
  // Drops are pulsed on odd cycles; last_drop also pulses on the final STOP cycle.
  task automatic send_frame(input logic [127:0] snap, input logic [4:0] len,
                            input int drops, input bit last_drop, input int stop_at);
    logic [7:0] exp_b[$];
    logic [7:0] got[$];
    logic [7:0] cur;
    logic       exp_tx;
    int         eff, total, pulsed, busy_cnt, b, p;
    bit         pulse;

    eff   = (len > 5'd16) ? 16 : int'(len);
    total = eff * 10 * int'(DIV);
    for (int k = eff - 1; k >= 0; k--) exp_b.push_back(snap[8*k +: 8]);

    bus.tx_show    = snap;
    bus.show_len   = len;
    bus.show_valid = 1'b1;
    cycle();
    bus.show_valid = 1'b0;

    pulsed   = 0;
    busy_cnt = 0;
    cur      = '0;
    for (int c = 0; c < total && c < stop_at; c++) begin
      b = c / int'(DIV);
      p = b % 10;
      if (p == 0)      exp_tx = 1'b0;
      else if (p == 9) exp_tx = 1'b1;
      else             exp_tx = exp_b[b / 10][p - 1];
      chk("tx_line", 32'(bus.tx), 32'(exp_tx));
      chk("busy_in_frame", 32'(bus.busy), 32'd1);
      chk("ready_in_frame", 32'(bus.show_ready), 32'd0);
      if (bus.busy) busy_cnt++;
      if ((c % int'(DIV)) == int'(DIV / 2) && p >= 1 && p <= 8) begin
        cur[p - 1] = bus.tx;
        if (p == 8) got.push_back(cur);
      end
      pulse = (pulsed < drops && (c % 2) == 1) || (last_drop && c == total - 1);
      if (pulse) begin
        pulsed++;
        drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
      end
      bus.show_valid = pulse;
      bus.tx_show    = rand128();
      bus.show_len   = 5'($urandom);
      cycle();
    end
    bus.show_valid = 1'b0;

    if (stop_at >= total) begin
      chk("busy_cycles", 32'(busy_cnt), 32'(total));
      chk("byte_count", 32'(got.size()), 32'(eff));
      for (int i = 0; i < got.size() && i < eff; i++) chk("byte_value", 32'(got[i]), 32'(exp_b[i]));
      chk_idle("frame_end");
    end
  endtask

  initial begin
    logic [127:0] snap;
    bus.tx_show    = '0;
    bus.show_len   = '0;
    bus.show_valid = 1'b0;

    // Reset and idle line
    reset = 1'b1;
    repeat (3) cycle();
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("idle_tx", 32'(bus.tx), 32'd1);
    end
    chk_idle("idle");

    // Two-byte frame with three drops, then a drop on the final STOP cycle
    send_frame(128'hA55A, 5'd2, 3, 1'b0, 1 << 30);
    chk("drop_three", 32'(bus.drop_cnt), 32'd3);
    send_frame(128'hA55A, 5'd2, 0, 1'b1, 1 << 30);
    chk("drop_at_return", 32'(bus.drop_cnt), 32'd4);

    // Accepted on the cycle right after returning to IDLE: full 16-byte frame
    snap = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send_frame(snap, 5'd16, 0, 1'b0, 1 << 30);

    // Saturating drop counter
    send_frame(rand128(), 5'd16, 300, 1'b0, 1 << 30);
    chk("drop_saturate", 32'(bus.drop_cnt), 32'd255);

    // Zero-length snapshot is swallowed silently
    bus.tx_show    = rand128();
    bus.show_len   = 5'd0;
    bus.show_valid = 1'b1;
    cycle();
    bus.show_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_idle("len_zero");
      cycle();
    end

    // Oversized length is clamped to 16 bytes
    send_frame(rand128(), 5'd20, 0, 1'b0, 1 << 30);

    // Reset in the middle of the second byte's data bits
    send_frame(rand128(), 5'd3, 0, 1'b0, 50);
    reset = 1'b1;
    cycle();
    drop_exp = 0;
    chk_idle("mid_reset");
    reset = 1'b0;
    cycle();
    chk_idle("post_reset");
    send_frame(rand128(), 5'd3, 0, 1'b0, 1 << 30);

    // Randomized frames
    for (int n = 0; n < 4; n++) begin
      send_frame(rand128(), 5'($urandom_range(1, 20)), int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1 << 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
